// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue stage: field encodings,
// ALU opcodes, overflow exception codes and the registered issue packet.
package alu_issue_pkg;

   localparam int unsigned PKT_DATA_W = 32;
   localparam int unsigned PKT_REG_AW = 5;
   localparam int unsigned OP_W       = 5;
   localparam int unsigned INSTR_W    = 32;

   localparam logic [OP_W-1:0] R_TYPE = 5'b00000;
   localparam logic [OP_W-1:0] ADDI   = 5'b00101;

   localparam logic [OP_W-1:0] ADD = 5'd0;
   localparam logic [OP_W-1:0] SUB = 5'd1;
   localparam logic [OP_W-1:0] AND = 5'd2;
   localparam logic [OP_W-1:0] OR  = 5'd3;
   localparam logic [OP_W-1:0] SLL = 5'd4;
   localparam logic [OP_W-1:0] SRA = 5'd5;

   typedef enum logic [1:0] {
      EXC_NONE = 2'd0,
      EXC_ADD  = 2'd1,
      EXC_ADDI = 2'd2,
      EXC_SUB  = 2'd3
   } exc_t;

   typedef struct packed {
      logic [PKT_DATA_W-1:0] operand_a;
      logic [PKT_DATA_W-1:0] operand_b;
      logic [OP_W-1:0]       aluop;
      logic [OP_W-1:0]       shamt;
      logic [PKT_REG_AW-1:0] rd;
      logic                  we;
      exc_t                  exc;
      logic                  illegal;
   } issue_pkt_t;

   // True for R-type ALU ops in the decodable range ADD..SRA
   function automatic logic alu_op_legal(input logic [OP_W-1:0] op);
      return (op <= SRA);
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Upstream instruction handshake and downstream registered ALU-input bus.
// slave = the issue stage's view, master = the driver/consumer view.
interface alu_issue_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_instr;
   logic [DATA_W-1:0] in_rs_data;
   logic [DATA_W-1:0] in_rt_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_operandA;
   logic [DATA_W-1:0] out_operandB;
   logic [4:0]        out_aluop;
   logic [4:0]        out_shamt;
   logic [REG_AW-1:0] out_rd;
   logic              out_we;
   logic [1:0]        out_exc;
   logic              out_illegal;

   modport slave (
      input  in_valid, in_instr, in_rs_data, in_rt_data, flush, out_ready,
      output in_ready, out_valid, out_operandA, out_operandB, out_aluop,
             out_shamt, out_rd, out_we, out_exc, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_rs_data, in_rt_data, flush, out_ready,
      input  in_ready, out_valid, out_operandA, out_operandB, out_aluop,
             out_shamt, out_rd, out_we, out_exc, out_illegal
   );
endinterface

// File: rtl/issue_skid_buffer.sv
// Valid/ready register for issue_pkt_t. With ALU_ISSUE_SKID_EN defined a
// skid entry is added and in_ready becomes a registered output.
module issue_skid_buffer
   import alu_issue_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       flush,
   input  logic       in_valid,
   output logic       in_ready,
   input  issue_pkt_t in_pkt,
   output logic       out_valid,
   input  logic       out_ready,
   output issue_pkt_t out_pkt
);

   logic       accept_c;
   logic       transfer_c;
   logic       main_valid_q, main_valid_d;
   issue_pkt_t main_pkt_q, main_pkt_d;

   assign accept_c   = in_valid && in_ready;
   assign transfer_c = main_valid_q && out_ready;
   assign out_valid  = main_valid_q;
   assign out_pkt    = main_pkt_q;

`ifdef ALU_ISSUE_SKID_EN
   logic       skid_valid_q, skid_valid_d;
   issue_pkt_t skid_pkt_q, skid_pkt_d;
   logic       in_ready_q, in_ready_d;

   assign in_ready = in_ready_q;

   // in_ready_q tracks !skid_valid_q, so no accept can arrive while the skid is full
   always_comb begin
      main_valid_d = main_valid_q;
      main_pkt_d   = main_pkt_q;
      skid_valid_d = skid_valid_q;
      skid_pkt_d   = skid_pkt_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         if (transfer_c) begin
            main_pkt_d   = skid_pkt_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept_c) begin
         if (!main_valid_q || transfer_c) begin
            main_valid_d = 1'b1;
            main_pkt_d   = in_pkt;
         end else begin
            skid_valid_d = 1'b1;
            skid_pkt_d   = in_pkt;
         end
      end else if (transfer_c) begin
         main_valid_d = 1'b0;
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         skid_valid_q <= 1'b0;
         skid_pkt_q   <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_pkt_q   <= skid_pkt_d;
         in_ready_q   <= in_ready_d;
      end
   end
`else
   assign in_ready = !main_valid_q || out_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_pkt_d   = main_pkt_q;
      if (flush) begin
         main_valid_d = 1'b0;
      end else if (accept_c) begin
         main_valid_d = 1'b1;
         main_pkt_d   = in_pkt;
      end else if (transfer_c) begin
         main_valid_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         main_valid_q <= 1'b0;
         main_pkt_q   <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_pkt_q   <= main_pkt_d;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the 32-bit ALU: decodes R-type and addi and
// registers ALU inputs plus writeback metadata. Option: ALU_ISSUE_SKID_EN.
module alu_issue_stage
   import alu_issue_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned REG_AW = 5
) (
   input  logic      clock,
   input  logic      reset_n,
   alu_issue_if.slave bus
);

   localparam int unsigned IMM_W = 17;

   logic [OP_W-1:0]   opcode_c;
   logic [REG_AW-1:0] rd_c;
   logic [OP_W-1:0]   shamt_c;
   logic [OP_W-1:0]   aluop_c;
   logic [IMM_W-1:0]  imm_c;
   logic [DATA_W-1:0] imm_sext_c;
   issue_pkt_t        dec_pkt_c;
   issue_pkt_t        out_pkt;
   logic              unused_rs_field;

   assign opcode_c   = bus.in_instr[31:27];
   assign rd_c       = bus.in_instr[26:22];
   assign shamt_c    = bus.in_instr[11:7];
   assign aluop_c    = bus.in_instr[6:2];
   assign imm_c      = bus.in_instr[16:0];
   assign imm_sext_c = {{(DATA_W-IMM_W){imm_c[IMM_W-1]}}, imm_c};

   // Register indices are resolved upstream; only the read data is used here
   assign unused_rs_field = ^bus.in_instr[21:17];

   // Anything not recognised goes out as an illegal NOP with writeback off
   always_comb begin
      dec_pkt_c         = '0;
      dec_pkt_c.illegal = 1'b1;
      if (opcode_c == R_TYPE && alu_op_legal(aluop_c)) begin
         dec_pkt_c.operand_a = bus.in_rs_data;
         dec_pkt_c.operand_b = bus.in_rt_data;
         dec_pkt_c.aluop     = aluop_c;
         dec_pkt_c.shamt     = shamt_c;
         dec_pkt_c.rd        = rd_c;
         dec_pkt_c.we        = (rd_c != '0);
         dec_pkt_c.illegal   = 1'b0;
         if (aluop_c == ADD) begin
            dec_pkt_c.exc = EXC_ADD;
         end else if (aluop_c == SUB) begin
            dec_pkt_c.exc = EXC_SUB;
         end else begin
            dec_pkt_c.exc = EXC_NONE;
         end
      end else if (opcode_c == ADDI) begin
         dec_pkt_c.operand_a = bus.in_rs_data;
         dec_pkt_c.operand_b = imm_sext_c;
         dec_pkt_c.aluop     = ADD;
         dec_pkt_c.rd        = rd_c;
         dec_pkt_c.we        = (rd_c != '0);
         dec_pkt_c.exc       = EXC_ADDI;
         dec_pkt_c.illegal   = 1'b0;
      end
   end

   issue_skid_buffer u_skid (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (bus.flush),
      .in_valid  (bus.in_valid),
      .in_ready  (bus.in_ready),
      .in_pkt    (dec_pkt_c),
      .out_valid (bus.out_valid),
      .out_ready (bus.out_ready),
      .out_pkt   (out_pkt)
   );

   assign bus.out_operandA = out_pkt.operand_a;
   assign bus.out_operandB = out_pkt.operand_b;
   assign bus.out_aluop    = out_pkt.aluop;
   assign bus.out_shamt    = out_pkt.shamt;
   assign bus.out_rd       = out_pkt.rd;
   assign bus.out_we       = out_pkt.we;
   assign bus.out_exc      = out_pkt.exc;
   assign bus.out_illegal  = out_pkt.illegal;

endmodule
